// File: rtl/ysyx_22041412_exec_unit.sv
// Purpose: RV64 decode, 32x64 register file and ALU, with an optional M extension (macro YSYX_22041412_MUL_EN).
// Latency: decode, register reads and ALU are combinational; M ops take MUL_LAT stall cycles before the result is valid.
// Backpressure: alu_stall is high while an M op is counting; the caller holds the operands stable until it drops.
// Ports: instr -> opcode/func3/func7/rs1/rs2/rd/imm/v1_type/v2_type/mul_en (decode);
//        rf_wen/rf_waddr/rf_wdata -> busA/busB (register file);
//        alu_src1/alu_src2/alu_imm/alu_opcode/alu_func3/alu_func7/alu_mul_en -> alu_result/alu_stall (ALU).
module ysyx_22041412_exec_unit #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic        func7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [63:0] imm,
    output logic [1:0]  v1_type,
    output logic [1:0]  v2_type,
    output logic        mul_en,
    output logic [63:0] busA,
    output logic [63:0] busB,
    input  logic        rf_wen,
    input  logic [4:0]  rf_waddr,
    input  logic [63:0] rf_wdata,
    input  logic [63:0] alu_src1,
    input  logic [63:0] alu_src2,
    input  logic [63:0] alu_imm,
    input  logic [6:0]  alu_opcode,
    input  logic [2:0]  alu_func3,
    input  logic        alu_func7,
    input  logic        alu_mul_en,
    output logic [63:0] alu_result,
    output logic        alu_stall
);
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // ---------------- decode ----------------
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{52{instr[31]}}, instr[31:20]};
    assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{32{instr[31]}}, instr[31:12], 12'd0};
    assign imm_j = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        opcode  = instr[6:0];
        func3   = instr[14:12];
        func7   = instr[30];
        rs1     = 5'd0;
        rs2     = 5'd0;
        rd      = 5'd0;
        imm     = 64'd0;
        v1_type = 2'd0;
        v2_type = 2'd0;
        mul_en  = 1'b0;
        case (instr[6:0])
            OPC_LUI: begin
                rd = instr[11:7]; imm = imm_u; v2_type = 2'd1;
            end
            OPC_AUIPC: begin
                rd = instr[11:7]; imm = imm_u; v1_type = 2'd1; v2_type = 2'd1;
            end
            OPC_JAL: begin
                rd = instr[11:7]; imm = imm_j; v1_type = 2'd1; v2_type = 2'd1;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32: begin
                rs1 = instr[19:15]; rd = instr[11:7]; imm = imm_i; v2_type = 2'd1;
            end
            OPC_STORE: begin
                rs1 = instr[19:15]; rs2 = instr[24:20]; imm = imm_s; v2_type = 2'd1;
            end
            OPC_BRANCH: begin
                rs1 = instr[19:15]; rs2 = instr[24:20]; imm = imm_b;
            end
            OPC_OP, OPC_OP32: begin
                rs1 = instr[19:15]; rs2 = instr[24:20]; rd = instr[11:7];
`ifdef YSYX_22041412_MUL_EN
                mul_en = (instr[31:25] == 7'b0000001);
`endif
            end
            OPC_SYSTEM: begin
                // rs1 field doubles as zimm for the csr*i forms; CSR address is unsigned
                rs1 = instr[19:15]; rd = instr[11:7]; imm = {52'd0, instr[31:20]};
                if (instr[14]) v1_type = 2'd2;
            end
            default: ;
        endcase
    end

    // ---------------- register file ----------------
    logic [63:0] regs [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
        end else if (rf_wen && rf_waddr != 5'd0) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    assign busA = (rst || rs1 == 5'd0) ? 64'd0 : regs[rs1];
    assign busB = (rst || rs2 == 5'd0) ? 64'd0 : regs[rs2];

    // ---------------- ALU ----------------
    logic [63:0] a, b, base_res;
    logic [31:0] w32;
    logic        taken, m_op;
    assign a    = alu_src1;
    assign b    = alu_src2;
    assign m_op = alu_mul_en && (alu_opcode == OPC_OP || alu_opcode == OPC_OP32);

    always_comb begin
        base_res = 64'd0;
        case (alu_func3)
            // func7 is an immediate bit for OP-IMM, so subtraction only exists on OP
            3'd0: base_res = (alu_func7 && alu_opcode == OPC_OP) ? a - b : a + b;
            3'd1: base_res = a << b[5:0];
            3'd2: base_res = {63'd0, $signed(a) < $signed(b)};
            3'd3: base_res = {63'd0, a < b};
            3'd4: base_res = a ^ b;
            3'd5: if (alu_func7) base_res = $signed(a) >>> b[5:0];
                  else           base_res = a >> b[5:0];
            3'd6: base_res = a | b;
            default: base_res = a & b;
        endcase
    end

    always_comb begin
        w32 = 32'd0;
        case (alu_func3)
            3'd0: w32 = (alu_func7 && alu_opcode == OPC_OP32) ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
            3'd1: w32 = a[31:0] << b[4:0];
            3'd5: if (alu_func7) w32 = $signed(a[31:0]) >>> b[4:0];
                  else           w32 = a[31:0] >> b[4:0];
            default: ;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (alu_func3)
            3'd0: taken = (a == b);
            3'd1: taken = (a != b);
            3'd4: taken = ($signed(a) <  $signed(b));
            3'd5: taken = ($signed(a) >= $signed(b));
            3'd6: taken = (a <  b);
            3'd7: taken = (a >= b);
            default: ;
        endcase
    end

`ifdef YSYX_22041412_MUL_EN
    logic [127:0] mul_a, mul_b, prod;
    logic [63:0]  q64, r64, m_res;
    logic [31:0]  q32, r32, mw32;

    // One 128-bit multiplier serves every form: operands are sign- or zero-extended per func3
    always_comb begin
        mul_a = (alu_func3 == 3'd1 || alu_func3 == 3'd2) ? {{64{a[63]}}, a} : {64'd0, a};
        mul_b = (alu_func3 == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
        prod  = mul_a * mul_b;
    end

    // func3[0]=0 selects the signed div/rem forms
    always_comb begin
        if (b == 64'd0) begin
            q64 = '1; r64 = a;
        end else if (!alu_func3[0] && a == {1'b1, 63'd0} && b == '1) begin
            q64 = a; r64 = 64'd0;
        end else if (!alu_func3[0]) begin
            q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b);
        end else begin
            q64 = a / b; r64 = a % b;
        end
    end

    always_comb begin
        if (b[31:0] == 32'd0) begin
            q32 = '1; r32 = a[31:0];
        end else if (!alu_func3[0] && a[31:0] == {1'b1, 31'd0} && b[31:0] == '1) begin
            q32 = a[31:0]; r32 = 32'd0;
        end else if (!alu_func3[0]) begin
            q32 = $signed(a[31:0]) / $signed(b[31:0]); r32 = $signed(a[31:0]) % $signed(b[31:0]);
        end else begin
            q32 = a[31:0] / b[31:0]; r32 = a[31:0] % b[31:0];
        end
    end

    always_comb begin
        m_res = r64;
        mw32  = 32'd0;
        case (alu_func3)
            3'd0:             m_res = prod[63:0];
            3'd1, 3'd2, 3'd3: m_res = prod[127:64];
            3'd4, 3'd5:       m_res = q64;
            default:          m_res = r64;
        endcase
        case (alu_func3)
            3'd0:       mw32 = prod[31:0];
            3'd4, 3'd5: mw32 = q32;
            3'd6, 3'd7: mw32 = r32;
            default:    ;
        endcase
    end
`endif

    always_comb begin
        alu_result = 64'd0;
        case (alu_opcode)
            OPC_OP, OPC_OP_IMM:                        alu_result = base_res;
            OPC_OP32, OPC_OP_IMM32:                    alu_result = {{32{w32[31]}}, w32};
            OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL:   alu_result = a + b;
            OPC_LUI:                                   alu_result = b;
            OPC_JALR:                                  alu_result = (a + alu_imm) & ~64'd1;
            OPC_BRANCH:                                alu_result = {63'd0, taken};
            default:                                   ;
        endcase
        if (m_op) begin
`ifdef YSYX_22041412_MUL_EN
            alu_result = (alu_opcode == OPC_OP32) ? {{32{mw32[31]}}, mw32} : m_res;
`else
            alu_result = 64'd0;
`endif
        end
    end

    // ---------------- M-op latency counter ----------------
`ifdef YSYX_22041412_MUL_EN
    localparam logic [3:0] LAT = 4'(MUL_LAT);
    logic [3:0] cnt;

    // Clearing whenever m_op drops makes an abandoned op and a reset both restart from a full stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      cnt <= 4'd0;
        else if (!m_op || cnt == LAT) cnt <= 4'd0;
        else                          cnt <= cnt + 4'd1;
    end

    assign alu_stall = m_op && (cnt != LAT) && !rst;
`else
    assign alu_stall = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22041412_exec_unit.sv
// Purpose: directed self-checking bench for ysyx_22041412_exec_unit (decode, register file, ALU, M latency).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled before the next edge.
// Backpressure: M-op tests step a fixed number of cycles and check alu_stall on each.
module tb_ysyx_22041412_exec_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        func7;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic [1:0]  v1_type, v2_type;
    logic        mul_en;
    logic [63:0] busA, busB;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [63:0] alu_src1, alu_src2, alu_imm;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_func3;
    logic        alu_func7, alu_mul_en;
    logic [63:0] alu_result;
    logic        alu_stall;

    int n_chk  = 0;
    int n_pass = 0;

    ysyx_22041412_exec_unit #(.MUL_LAT(3)) dut (
        .clk(clk), .rst(rst), .instr(instr),
        .opcode(opcode), .func3(func3), .func7(func7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .v1_type(v1_type), .v2_type(v2_type), .mul_en(mul_en),
        .busA(busA), .busB(busB),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_imm(alu_imm),
        .alu_opcode(alu_opcode), .alu_func3(alu_func3), .alu_func7(alu_func7),
        .alu_mul_en(alu_mul_en), .alu_result(alu_result), .alu_stall(alu_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [63:0] s1, input logic [63:0] s2, input logic [63:0] im,
                           input logic men);
        alu_opcode = op; alu_func3 = f3; alu_func7 = f7;
        alu_src1 = s1; alu_src2 = s2; alu_imm = im; alu_mul_en = men;
        #1;
    endtask

`ifdef YSYX_22041412_MUL_EN
    // Runs one M op through its full stall window, then idles one cycle so the counter is back at 0
    task automatic m_run(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [63:0] s1, input logic [63:0] s2, input logic [63:0] exp);
        set_alu(op, f3, 1'b0, s1, s2, 64'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            chk({tag, "_stall"}, {63'd0, alu_stall}, 64'd1);
            step();
        end
        chk({tag, "_done"}, {63'd0, alu_stall}, 64'd0);
        chk({tag, "_res"}, alu_result, exp);
        alu_mul_en = 1'b0;
        step();
    endtask
`endif

    initial begin
        rst = 1'b1; instr = 32'h000280B3;
        rf_wen = 1'b0; rf_waddr = 5'd0; rf_wdata = 64'd0;
        alu_src1 = 64'd0; alu_src2 = 64'd0; alu_imm = 64'd0;
        alu_opcode = 7'd0; alu_func3 = 3'd0; alu_func7 = 1'b0; alu_mul_en = 1'b0;
        #2;
        chk("rst_busA", busA, 64'd0);
        chk("rst_stall", {63'd0, alu_stall}, 64'd0);
        #10 rst = 1'b0;
        step();

        // register file
        rf_wen = 1'b1; rf_waddr = 5'd5; rf_wdata = 64'h1234;
        step();
        rf_waddr = 5'd0; rf_wdata = 64'hFFFF;
        step();
        rf_wen = 1'b0;
        chk("rf_x5", busA, 64'h1234);
        chk("rf_x0_b", busB, 64'd0);
        instr = 32'h005000B3; #1;
        chk("rf_x0_a", busA, 64'd0);
        chk("rf_x5_b", busB, 64'h1234);
        instr = 32'h000280B3;
        rf_wen = 1'b1; rf_waddr = 5'd5; rf_wdata = 64'hBEEF; #1;
        chk("rf_old", busA, 64'h1234);
        step();
        rf_wen = 1'b0;
        chk("rf_new", busA, 64'hBEEF);

        // decode
        instr = 32'hFFF10093; #1;
        chk("dec_addi_op", {57'd0, opcode}, 64'h13);
        chk("dec_addi_rd", {59'd0, rd}, 64'd1);
        chk("dec_addi_rs1", {59'd0, rs1}, 64'd2);
        chk("dec_addi_rs2", {59'd0, rs2}, 64'd0);
        chk("dec_addi_imm", imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("dec_addi_v2", {62'd0, v2_type}, 64'd1);
        chk("dec_addi_mul", {63'd0, mul_en}, 64'd0);
        instr = 32'h0020A423; #1;
        chk("dec_sw_imm", imm, 64'd8);
        chk("dec_sw_rd", {59'd0, rd}, 64'd0);
        chk("dec_sw_rs2", {59'd0, rs2}, 64'd2);
        chk("dec_sw_f3", {61'd0, func3}, 64'd2);
        instr = 32'h800001B7; #1;
        chk("dec_lui_imm", imm, 64'hFFFF_FFFF_8000_0000);
        chk("dec_lui_rs1", {59'd0, rs1}, 64'd0);
        chk("dec_lui_rd", {59'd0, rd}, 64'd3);
        instr = 32'hFE208FE3; #1;
        chk("dec_beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("dec_beq_v2", {62'd0, v2_type}, 64'd0);
        instr = 32'h00000097; #1;
        chk("dec_auipc_v1", {62'd0, v1_type}, 64'd1);
        instr = 32'h8002D073; #1;
        chk("dec_csr_v1", {62'd0, v1_type}, 64'd2);
        chk("dec_csr_imm", imm, 64'h800);
        instr = 32'h023100B3; #1;
        chk("dec_mul_f7", {63'd0, func7}, 64'd0);
`ifdef YSYX_22041412_MUL_EN
        chk("dec_mul_en", {63'd0, mul_en}, 64'd1);
`else
        chk("dec_mul_en", {63'd0, mul_en}, 64'd0);
`endif

        // ALU
        set_alu(7'b0111011, 3'd0, 1'b0, 64'h7FFF_FFFF, 64'd1, 64'd0, 1'b0);
        chk("alu_addw", alu_result, 64'hFFFF_FFFF_8000_0000);
        set_alu(7'b1100111, 3'd0, 1'b0, 64'h8000_0003, 64'd0, 64'd0, 1'b0);
        chk("alu_jalr", alu_result, 64'h8000_0002);
        set_alu(7'b1100011, 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b0);
        chk("alu_blt", alu_result, 64'd1);
        set_alu(7'b1100011, 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1'b0);
        chk("alu_bltu", alu_result, 64'd0);
        set_alu(7'b0110011, 3'd0, 1'b1, 64'd5, 64'd7, 64'd0, 1'b0);
        chk("alu_sub", alu_result, 64'hFFFF_FFFF_FFFF_FFFE);
        set_alu(7'b0010011, 3'd0, 1'b1, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        chk("alu_addi_neg", alu_result, 64'd9);
        set_alu(7'b0110011, 3'd5, 1'b1, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 1'b0);
        chk("alu_sra", alu_result, 64'hF800_0000_0000_0000);
        set_alu(7'b0110011, 3'd5, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 1'b0);
        chk("alu_srl", alu_result, 64'h0800_0000_0000_0000);
        set_alu(7'b0111011, 3'd5, 1'b1, 64'h8000_0000, 64'd1, 64'd0, 1'b0);
        chk("alu_sraw", alu_result, 64'hFFFF_FFFF_C000_0000);
        set_alu(7'b0110111, 3'd0, 1'b0, 64'd99, 64'h1234, 64'd0, 1'b0);
        chk("alu_lui", alu_result, 64'h1234);
        set_alu(7'b1110011, 3'd1, 1'b0, 64'd3, 64'd4, 64'd0, 1'b0);
        chk("alu_system", alu_result, 64'd0);
        chk("alu_nostall", {63'd0, alu_stall}, 64'd0);

`ifdef YSYX_22041412_MUL_EN
        m_run("mul", 7'b0110011, 3'd0, 64'd3, 64'd5, 64'd15);
        m_run("div0", 7'b0110011, 3'd4, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        m_run("rem0", 7'b0110011, 3'd6, 64'd7, 64'd0, 64'd7);
        m_run("divovf", 7'b0110011, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000);
        m_run("mulhu", 7'b0110011, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1);
        m_run("divw", 7'b0111011, 3'd4, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);

        // mul_en dropped mid-count: stall falls at once and the next op waits a full window
        set_alu(7'b0110011, 3'd0, 1'b0, 64'd3, 64'd5, 64'd0, 1'b1);
        step();
        alu_mul_en = 1'b0; #1;
        chk("drop_stall", {63'd0, alu_stall}, 64'd0);
        step();
        m_run("mul_after_drop", 7'b0110011, 3'd0, 64'd6, 64'd7, 64'd42);

        // reset in the second stall cycle
        instr = 32'h000280B3;
        set_alu(7'b0110011, 3'd0, 1'b0, 64'd3, 64'd5, 64'd0, 1'b1);
        step();
        rst = 1'b1; #1;
        chk("rstm_stall", {63'd0, alu_stall}, 64'd0);
        chk("rstm_busA", busA, 64'd0);
        #1 rst = 1'b0; #1;
        chk("rstm_restart", {63'd0, alu_stall}, 64'd1);
        step();
        chk("rstm_c1", {63'd0, alu_stall}, 64'd1);
        step();
        chk("rstm_c2", {63'd0, alu_stall}, 64'd1);
        step();
        chk("rstm_done", {63'd0, alu_stall}, 64'd0);
        chk("rstm_res", alu_result, 64'd15);
        alu_mul_en = 1'b0;
        step();
`else
        set_alu(7'b0110011, 3'd0, 1'b0, 64'd3, 64'd5, 64'd0, 1'b1);
        chk("nom_stall", {63'd0, alu_stall}, 64'd0);
        chk("nom_res", alu_result, 64'd0);
        step();
        chk("nom_stall2", {63'd0, alu_stall}, 64'd0);

        instr = 32'h000280B3;
        rst = 1'b1; #1;
        chk("rstm_busA", busA, 64'd0);
        chk("rstm_stall", {63'd0, alu_stall}, 64'd0);
        #1 rst = 1'b0; #1;
        chk("rstm_after", busA, 64'd0);
        alu_mul_en = 1'b0;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ysyx_22041412_exec_unit.md
YSYX_22041412_EXEC_UNIT -- requirements
Module: ysyx_22041412_exec_unit

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, giving the number of stall cycles for an M-extension op (range 1..15).
REQ-002 SHALL have port clk, in, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, in, 1: asynchronous, active-high reset.
REQ-004 SHALL have port instr, in, 32: instruction to decode.
REQ-005 SHALL have port opcode, out, 7: instr[6:0].
REQ-006 SHALL have port func3, out, 3: instr[14:12].
REQ-007 SHALL have port func7, out, 1: instr[30].
REQ-008 SHALL have ports rs1/rs2/rd, out, 5 each: instr[19:15]/[24:20]/[11:7], forced to 0 where the format lacks the field.
REQ-009 SHALL have port imm, out, 64: sign-extended immediate (I/S/B/U/J per opcode); CSR address zero-extended for SYSTEM; 0 for R-type.
REQ-010 SHALL have ports v1_type/v2_type, out, 2 each: operand selectors. v1: 0=rs1, 1=pc, 2=zimm. v2: 0=rs2, 1=imm.
REQ-011 SHALL have port mul_en, out, 1: OP or OP-32 with instr[31:25]=0000001.
REQ-012 SHALL have ports busA/busB, out, 64: register file read data for rs1/rs2.
REQ-013 SHALL have ports rf_wen (in, 1), rf_waddr (in, 5) and rf_wdata (in, 64): register write port.
REQ-014 SHALL have ports alu_src1 and alu_src2, in, 64: ALU operands.
REQ-015 SHALL have ports alu_imm (in, 64), alu_opcode (in, 7), alu_func3 (in, 3), alu_func7 (in, 1) and alu_mul_en (in, 1): ALU control.
REQ-016 SHALL have ports alu_result (out, 64) and alu_stall (out, 1).

Function
REQ-017 Decode SHALL be purely combinational.
- v1_type=1: auipc, jal.
- v1_type=2: SYSTEM with func3[2]=1.
- v2_type=1: OP-IMM, OP-IMM-32, load, store, lui, auipc, jal, jalr.
- v1_type=0 and v2_type=0 in all other cases.
REQ-018 Register file SHALL hold 32x64 bits with combinational reads.
- Write on the clk edge when rf_wen=1 and rf_waddr!=0.
- x0 SHALL always read 0.
- A same-cycle read of a register being written SHALL return the old value; there is no internal bypass.
REQ-019 ALU SHALL be combinational except for M-op latency.
- OP/OP-IMM: RV64I add, sub, sll, slt, sltu, xor, srl, sra, or, and; alu_func7 selects sub/sra; shamt is 6 bits.
- OP-32/OP-IMM-32: 32-bit operation, result sign-extended to 64 bits.
- load, store, auipc, jal: alu_src1+alu_src2.
- lui: alu_src2.
- jalr: (alu_src1+alu_imm) with bit 0 cleared.
- B-type: {63'b0, taken}, compared per func3 (beq, bne, blt, bge, bltu, bgeu).
- SYSTEM and unknown opcodes: 0.
REQ-020 M ops SHALL implement mul, mulh, mulhsu, mulhu, div, divu, rem, remu and the W forms.
- Division by zero: quotient all-ones, remainder = dividend.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
REQ-021 M-op latency:
- When alu_mul_en=1 and the op is OP/OP-32, alu_stall=1 combinationally until an internal counter reaches MUL_LAT.
- In the cycle the counter equals MUL_LAT, alu_stall=0 and alu_result is valid.
- The counter returns to 0 on the next edge.
- Operands are held stable by the caller while stalled.
- A back-to-back M op restarts the count.
REQ-022 If alu_mul_en deasserts mid-count, the counter SHALL clear on the next edge and alu_stall SHALL drop immediately.

Reset
REQ-023 rst=1 SHALL asynchronously clear all 32 registers and the latency counter.
- During reset alu_stall=0 and busA/busB=0.
- Combinational decode outputs follow instr.
REQ-024 Reset asserted mid M-op SHALL abort it; after release the op restarts with a full MUL_LAT stall.

Configuration
REQ-025 Macro YSYX_22041412_MUL_EN SHALL control M-extension support.
- Defined: M extension present as in REQ-020 to REQ-022.
- Undefined: mul_en=0, alu_stall=0 always, and M-encoded ops return 0.

Verification
REQ-026 Regfile: write x5=0x1234 then x0=0xFFFF -> busA(rs1=5)=0x1234, busA(rs1=0)=0; during a same-cycle write to x5 a read returns the old value.
REQ-027 Decode: instr 0xFFF10093 (addi x1,x2,-1) -> opcode=0x13, rd=1, rs1=2, imm=0xFFFFFFFFFFFFFFFF, v2_type=1, mul_en=0.
REQ-028 ALU: addw with src1=0x7FFFFFFF, src2=1 -> result=0xFFFFFFFF80000000; jalr with src1=0x80000003, imm=0 -> result=0x80000002.
REQ-029 Branch: blt with src1=-1, src2=0 -> result=1; bltu with the same operands -> result=0.
REQ-030 With the macro defined, mul 3*5 -> alu_stall=1 for 3 cycles, then result=15 with stall=0; div 7/0 -> result=0xFFFFFFFFFFFFFFFF.
REQ-031 rst asserted during M-op cycle 2 -> stall=0 immediately, all registers read 0.
